pipeline_stall_ctrl: RTL

//  Consumer of the ID-stage hazard requests (data_hazard_stall, control_hazard_stall).

---
 rtl/stall_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_ctrl_if.sv | 39 +++
 rtl/stall_down_counter.sv | 28 ++
 rtl/pipeline_stall_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared types and sizing for the pipeline stall controller.
// Optional perf counters: define STALL_PERF_CNT_EN.
package stall_ctrl_pkg;

   typedef enum logic {
      RUN       = 1'b0,
      CTRL_WAIT = 1'b1
   } state_t;

   localparam int CTRL_STALL_CYCLES_DEF = 1;
   localparam int DSTALL_MAX_DEF        = 4;
   localparam int CNT_W                 = 4;
   localparam int DCNT_W                = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard request / pipeline control bundle.
// Slave is the stall controller, master the control unit side.
interface pipeline_stall_ctrl_if;

   logic cpu_en;
   logic data_hazard_stall;
   logic control_hazard_stall;
   logic pc_en;
   logic if_id_en;
   logic if_id_flush;
   logic id_exe_bubble;
   logic stall_active;
   logic hazard_err;

   modport master (
      output cpu_en,
      output data_hazard_stall,
      output control_hazard_stall,
      input  pc_en,
      input  if_id_en,
      input  if_id_flush,
      input  id_exe_bubble,
      input  stall_active,
      input  hazard_err
   );

   modport slave (
      input  cpu_en,
      input  data_hazard_stall,
      input  control_hazard_stall,
      output pc_en,
      output if_id_en,
      output if_id_flush,
      output id_exe_bubble,
      output stall_active,
      output hazard_err
   );

endinterface

// File: rtl/stall_down_counter.sv
// Loadable down counter with enable and zero flag.
// Stops at zero; load has priority over decrement.
module stall_down_counter
   import stall_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns ID hazard requests into PC / IF-ID / ID-EXE controls.
// Optional perf counters: define STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int CTRL_STALL_CYCLES = CTRL_STALL_CYCLES_DEF,
   parameter int DSTALL_MAX        = DSTALL_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0]           perf_dstall_cnt,
   output logic [31:0]           perf_cstall_cnt
`endif
);

   localparam int LOAD_I =
      (CTRL_STALL_CYCLES > 1) ? CTRL_STALL_CYCLES - 2 : 0;
   localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_I);
   localparam logic [DCNT_W-1:0] DMAX = DCNT_W'(DSTALL_MAX);

   state_t state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_inc;
   logic run, dstall, flush, bubble;
   logic pc_en, if_id_en;
   logic cnt_load, cnt_dec, cnt_zero;
   logic err_q;

   assign run = rst_n & bus.cpu_en;

   always_comb begin
      state_d  = state_q;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      flush    = 1'b0;
      bubble   = 1'b0;
      dstall   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (run) begin
         unique case (state_q)
            RUN: begin
               if (bus.data_hazard_stall) begin
                  bubble = 1'b1;
                  dstall = 1'b1;
               end else if (bus.control_hazard_stall) begin
                  pc_en    = 1'b1;
                  if_id_en = 1'b1;
                  flush    = 1'b1;
                  if (CTRL_STALL_CYCLES > 1) begin
                     state_d  = CTRL_WAIT;
                     cnt_load = 1'b1;
                  end
               end else begin
                  pc_en    = 1'b1;
                  if_id_en = 1'b1;
               end
            end
            CTRL_WAIT: begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
               flush    = 1'b1;
               if (cnt_zero) state_d = RUN;
               else          cnt_dec = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   stall_down_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .en       (cnt_dec),
      .load_val (LOAD_V),
      .zero     (cnt_zero)
   );

   assign dcnt_inc = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         dcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (run) dcnt_q <= dstall ? dcnt_inc : '0;
         if (dstall && dcnt_inc == DMAX) err_q <= 1'b1;
      end
   end

   assign bus.pc_en         = pc_en;
   assign bus.if_id_en      = if_id_en;
   assign bus.if_id_flush   = flush;
   assign bus.id_exe_bubble = bubble;
   assign bus.stall_active  = run & (~pc_en | flush | bubble);
   assign bus.hazard_err    = err_q;

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_dstall_cnt <= '0;
         perf_cstall_cnt <= '0;
      end else begin
         if (dstall && perf_dstall_cnt != '1)
            perf_dstall_cnt <= perf_dstall_cnt + 1'b1;
         if (flush && perf_cstall_cnt != '1)
            perf_cstall_cnt <= perf_cstall_cnt + 1'b1;
      end
   end
`endif

endmodule
